// File: rtl/request_service_ctrl_if.sv
// Signal bundle between the request/service controller, the 8-input priority
// circuit and the single service unit.
interface request_service_ctrl_if;
    logic [7:0] req_in;
    logic [7:0] pend;
    logic [7:0] grant;
    logic       idle;
    logic       svc_valid;
    logic [2:0] svc_id;
    logic       svc_ready;
    logic       svc_done;
    logic       busy;
    logic       done_pulse;
    logic       timeout;
    logic       proto_err;

    modport master (
        input  req_in, grant, idle, svc_ready, svc_done,
        output pend, svc_valid, svc_id, busy, done_pulse, timeout, proto_err
    );

    modport slave (
        output req_in, grant, idle, svc_ready, svc_done,
        input  pend, svc_valid, svc_id, busy, done_pulse, timeout, proto_err
    );
endinterface

// File: rtl/request_service_ctrl.sv
// Front end for the 8-input priority circuit: latches request edges into pend,
// serves the granted channel through a valid/ready/done handshake with timeout.
module request_service_ctrl #(
    parameter int unsigned TW      = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    request_service_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? {TW{1'b0}} : TW'(TIMEOUT - 1);

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] encode8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                idx = 3'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_e        state_q, state_d;
    logic [7:0]    req_q;
    logic [7:0]    pend_q, pend_d;
    logic          svc_valid_q, svc_valid_d;
    logic [2:0]    svc_id_q, svc_id_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          proto_err_q, proto_err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    rise_s;
    logic [7:0]    clr_s;

    assign rise_s = bus.req_in & ~req_q;

    // Next-state, handshake outputs and pending-bit update.
    always_comb begin
        state_d     = state_q;
        svc_valid_d = svc_valid_q;
        svc_id_d    = svc_id_q;
        timer_d     = timer_q;
        clr_s       = 8'd0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        proto_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                svc_valid_d = 1'b0;
                if (!bus.idle && is_onehot(bus.grant)) begin
                    svc_id_d    = encode8(bus.grant);
                    svc_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (bus.idle && (bus.grant == 8'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    proto_err_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.svc_ready) begin
                    svc_valid_d = 1'b0;
                    timer_d     = {TW{1'b0}};
                    state_d     = ST_BUSY;
                end else begin
                    svc_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // Completion takes precedence over a timeout landing on the same edge.
                if (bus.svc_done) begin
                    clr_s   = 8'd1 << svc_id_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (TO_EN && (timer_q == TO_LAST)) begin
                    clr_s     = 8'd1 << svc_id_q;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                svc_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        // A new event on the bit being cleared keeps it pending.
        pend_d = (pend_q & ~clr_s) | rise_s;
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 8'd0;
            pend_q      <= 8'd0;
            svc_valid_q <= 1'b0;
            svc_id_q    <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            timer_q     <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            req_q       <= bus.req_in;
            pend_q      <= pend_d;
            svc_valid_q <= svc_valid_d;
            svc_id_q    <= svc_id_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.pend       = pend_q;
    assign bus.svc_valid  = svc_valid_q;
    assign bus.svc_id     = svc_id_q;
    assign bus.busy       = busy_q;
    assign bus.done_pulse = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.proto_err  = proto_err_q;

    request_service_ctrl_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .svc_valid  (svc_valid_q),
        .busy       (busy_q),
        .done_pulse (done_q),
        .timeout    (timeout_q),
        .proto_err  (proto_err_q)
    );

endmodule

// Structural invariants of the controller outputs.
module request_service_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic svc_valid,
    input logic busy,
    input logic done_pulse,
    input logic timeout,
    input logic proto_err
);

    a_valid_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        svc_valid |-> busy);

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({done_pulse, timeout, proto_err}));

endmodule

// File: tb/tb_request_service_ctrl.sv
// Directed bench: models the priority circuit (highest pending index wins) and
// walks the controller through service, priority, backpressure, timeout and error cases.
module tb_request_service_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic       force_en;
    logic [7:0] force_grant;
    logic       force_idle;
    logic [7:0] prio_grant;

    request_service_ctrl_if bus();

    request_service_ctrl #(.TW(8), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority circuit model: highest set pend bit wins.
    always_comb begin
        prio_grant = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (bus.pend[k]) begin
                prio_grant = 8'd1 << k;
            end else begin
                prio_grant = prio_grant;
            end
        end
    end

    assign bus.grant = force_en ? force_grant : prio_grant;
    assign bus.idle  = force_en ? force_idle  : (bus.pend == 8'd0);

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ids [3];
        logic [7:0] pends [3];
        ids   = '{3'd6, 3'd2, 3'd0};
        pends = '{8'h05, 8'h01, 8'h00};
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        force_en = 1'b0;
        force_grant = 8'd0;
        force_idle = 1'b0;
        bus.req_in = 8'd0;
        bus.svc_ready = 1'b1;
        bus.svc_done = 1'b0;
        #12;
        check_eq("rst_pend", bus.pend, 8'h00);
        check_eq("rst_valid", 8'(bus.svc_valid), 8'd0);
        check_eq("rst_busy", 8'(bus.busy), 8'd0);
        check_eq("rst_pulses", 8'({bus.done_pulse, bus.timeout, bus.proto_err}), 8'd0);
        rst_n = 1'b1;
        step();

        // Single event on channel 5
        bus.req_in = 8'h20;
        step();
        check_eq("se_pend", bus.pend, 8'h20);
        check_eq("se_valid0", 8'(bus.svc_valid), 8'd0);
        step();
        check_eq("se_valid", 8'(bus.svc_valid), 8'd1);
        check_eq("se_id", 8'(bus.svc_id), 8'd5);
        check_eq("se_busy", 8'(bus.busy), 8'd1);
        step();
        check_eq("se_accept", 8'({bus.busy, bus.svc_valid}), 8'b10);
        step();
        step();
        check_eq("se_busy5", 8'(bus.busy), 8'd1);
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        check_eq("se_done", 8'(bus.done_pulse), 8'd1);
        check_eq("se_pend0", bus.pend, 8'h00);
        check_eq("se_idle", 8'(bus.busy), 8'd0);
        step();
        check_eq("se_done_drop", 8'(bus.done_pulse), 8'd0);
        bus.req_in = 8'h00;
        step();

        // Priority order 6, 2, 0
        bus.req_in = 8'h45;
        step();
        check_eq("pr_pend", bus.pend, 8'h45);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("pr_valid", 8'(bus.svc_valid), 8'd1);
            check_eq("pr_id", 8'(bus.svc_id), 8'(ids[i]));
            step();
            check_eq("pr_busy", 8'({bus.busy, bus.svc_valid}), 8'b10);
            bus.svc_done = 1'b1;
            step();
            bus.svc_done = 1'b0;
            check_eq("pr_done", 8'(bus.done_pulse), 8'd1);
            check_eq("pr_pend_after", bus.pend, pends[i]);
        end
        step();
        check_eq("pr_quiet", 8'({bus.busy, bus.proto_err}), 8'd0);
        bus.req_in = 8'h00;
        step();

        // Backpressure on channel 4
        bus.svc_ready = 1'b0;
        bus.req_in = 8'h10;
        step();
        step();
        check_eq("bp_valid0", 8'(bus.svc_valid), 8'd1);
        check_eq("bp_id0", 8'(bus.svc_id), 8'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_valid", 8'(bus.svc_valid), 8'd1);
            check_eq("bp_id", 8'(bus.svc_id), 8'd4);
        end
        bus.svc_ready = 1'b1;
        step();
        check_eq("bp_accept", 8'({bus.busy, bus.svc_valid}), 8'b10);
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        check_eq("bp_pend", bus.pend, 8'h00);
        bus.req_in = 8'h00;
        step();

        // Timeout with TIMEOUT=4, then done on the 4th BUSY edge
        for (int run = 0; run < 2; run++) begin
            bus.req_in = 8'h02;
            step();
            step();
            step();
            check_eq("to_busy", 8'({bus.busy, bus.svc_valid}), 8'b10);
            for (int c = 0; c < 3; c++) begin
                step();
                check_eq("to_early", 8'({bus.busy, bus.timeout}), 8'b10);
            end
            bus.svc_done = (run == 1);
            step();
            bus.svc_done = 1'b0;
            check_eq("to_timeout", 8'(bus.timeout), (run == 0) ? 8'd1 : 8'd0);
            check_eq("to_done", 8'(bus.done_pulse), (run == 0) ? 8'd0 : 8'd1);
            check_eq("to_pend", bus.pend, 8'h00);
            check_eq("to_idle", 8'(bus.busy), 8'd0);
            bus.req_in = 8'h00;
            step();
        end

        // Set/clear collision on channel 3
        bus.req_in = 8'h08;
        step();
        step();
        step();
        bus.req_in = 8'h00;
        step();
        check_eq("co_busy", 8'(bus.busy), 8'd1);
        bus.req_in = 8'h08;
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        check_eq("co_done", 8'(bus.done_pulse), 8'd1);
        check_eq("co_pend", bus.pend, 8'h08);
        step();
        check_eq("co_reissue", 8'({bus.svc_valid, 5'd0, bus.svc_id[1:0]}), 8'h83);
        step();
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        check_eq("co_pend0", bus.pend, 8'h00);
        bus.req_in = 8'h00;
        step();

        // Illegal grant/idle combinations
        force_en = 1'b1;
        force_grant = 8'h03;
        force_idle = 1'b0;
        step();
        check_eq("pe_multi", 8'({bus.proto_err, bus.busy}), 8'b10);
        force_grant = 8'h10;
        force_idle = 1'b1;
        step();
        check_eq("pe_idle", 8'({bus.proto_err, bus.busy}), 8'b10);
        force_grant = 8'h00;
        force_idle = 1'b0;
        step();
        check_eq("pe_none", 8'({bus.proto_err, bus.busy}), 8'b10);
        force_en = 1'b0;
        step();
        check_eq("pe_clear", 8'(bus.proto_err), 8'd0);

        // Asynchronous reset during BUSY
        bus.req_in = 8'h01;
        step();
        step();
        step();
        check_eq("ar_busy", 8'(bus.busy), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_pend", bus.pend, 8'h00);
        check_eq("ar_outs", 8'({bus.svc_valid, bus.busy, bus.done_pulse, bus.timeout, bus.proto_err}), 8'd0);
        check_eq("ar_id", 8'(bus.svc_id), 8'd0);
        bus.req_in = 8'h00;
        #2;
        rst_n = 1'b1;
        step();
        step();
        check_eq("ar_no_replay", 8'({bus.busy, 7'd0}) | bus.pend, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
